// File: rtl/sr_muldiv_pkg.sv
// Shared encodings for the sr_muldiv iterative multiply/divide unit:
// op codes, FSM states and the M-extension instruction fields decoded by sr_control.
package sr_muldiv_pkg;

  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  localparam logic [6:0] RVOP_OP     = 7'b0110011;
  localparam logic [6:0] RVF7_MULDIV = 7'b0000001;
  localparam logic [2:0] RVF3_MUL    = 3'b000;
  localparam logic [2:0] RVF3_MULHU  = 3'b011;
  localparam logic [2:0] RVF3_DIVU   = 3'b101;
  localparam logic [2:0] RVF3_REMU   = 3'b111;

  // Operations whose result is known without iterating: zero factor, or zero divisor.
  function automatic logic md_trivial(input logic [1:0] op, input logic a_zero, input logic b_zero);
    return op[1] ? b_zero : (a_zero | b_zero);
  endfunction

endpackage

// File: rtl/sr_muldiv_if.sv
// start/busy/done request interface between sr_control (master) and sr_muldiv (slave).
interface sr_muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input result, busy, done);
  modport slave  (input start, op, a, b, output result, busy, done);

endinterface

// File: rtl/sr_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Multiply: {acc, sr} is the product register, sr holds the remaining multiplier bits.
module sr_muldiv_step #(parameter int WIDTH = 32) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sr_nxt
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shl_s;

  // Divide: remainder stays below the divisor, so WIDTH bits of acc are enough.
  always_comb begin
    sum_s = {1'b0, acc} + {1'b0, (sr[0] ? operand : {WIDTH{1'b0}})};
    shl_s = {acc, sr[WIDTH-1]};
    if (is_div) begin
      if (shl_s >= {1'b0, operand}) begin
        acc_nxt = WIDTH'(shl_s - {1'b0, operand});
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shl_s[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum_s[WIDTH:1];
      sr_nxt  = {sum_s[0], sr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sr_muldiv.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one radix-2 step per clock.
// Optional build macro SR_MULDIV_EARLY_OUT_EN: zero factor / zero divisor finishes after one CALC cycle.
module sr_muldiv
  import sr_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  sr_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state_r;
  md_state_t        state_nxt_s;
  logic             load_s;
  logic             step_s;
  logic             finish_s;
  logic             early_s;
  logic             early_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] sr_nxt_s;
  logic [WIDTH-1:0] early_res_s;
  logic [CNT_W-1:0] cnt_r;

  sr_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_r[1]),
    .acc     (acc_r),
    .sr      (sr_r),
    .operand (opnd_r),
    .acc_nxt (acc_nxt_s),
    .sr_nxt  (sr_nxt_s)
  );

`ifdef SR_MULDIV_EARLY_OUT_EN
  assign early_s = md_trivial(bus.op, bus.a == {WIDTH{1'b0}}, bus.b == {WIDTH{1'b0}});
`else
  assign early_s = 1'b0;
`endif

  // Shortcut results; sr_r still holds the dividend during the single early CALC cycle.
  always_comb begin
    if (!op_r[1]) begin
      early_res_s = {WIDTH{1'b0}};
    end else if (!op_r[0]) begin
      early_res_s = {WIDTH{1'b1}};
    end else begin
      early_res_s = sr_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and datapath strobes; DONE accepts a new start so back-to-back ops lose no cycle.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      MD_IDLE, MD_DONE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = MD_CALC;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_CALC: begin
        step_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          finish_s    = 1'b1;
          state_nxt_s = MD_DONE;
        end else begin
          state_nxt_s = MD_CALC;
        end
      end
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // Operand latch, iteration registers and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      sr_r     <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      early_r  <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      if (load_s) begin
        op_r    <= bus.op;
        opnd_r  <= bus.b;
        sr_r    <= bus.a;
        acc_r   <= {WIDTH{1'b0}};
        early_r <= early_s;
        cnt_r   <= early_s ? {CNT_W{1'b0}} : CNT_W'(WIDTH - 1);
      end else if (step_s) begin
        acc_r <= acc_nxt_s;
        sr_r  <= sr_nxt_s;
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (finish_s) begin
        result_r <= early_r ? early_res_s : (op_r[0] ? acc_nxt_s : sr_nxt_s);
      end
    end
  end

  assign bus.busy   = (state_r == MD_CALC);
  assign bus.done   = (state_r == MD_DONE);
  assign bus.result = result_r;

endmodule
